// File: rtl/float_div_seq_if.sv
// Operand/result bundle for float_div_seq: start request, binary32 operands,
// and the registered quotient with its busy/done/div_by_zero status.
interface float_div_seq_if;
  logic        start;
  logic [31:0] floatA;
  logic [31:0] floatB;
  logic [31:0] quotient;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, floatA, floatB,
    input  quotient, busy, done, div_by_zero
  );

  modport slave (
    input  start, floatA, floatB,
    output quotient, busy, done, div_by_zero
  );
endinterface

// File: rtl/float_div_seq.sv
// Sequential binary32 divider (restoring, 25 iterations, truncating, no denormals).
// Latency 26 edges normal, 1 edge special; start is ignored while busy, no queueing.
module float_div_seq (
  input  logic            clk,
  input  logic            reset,
  float_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

  state_t      state_q;
  logic [31:0] quot_q;
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;
  logic        spec_pend_q;
  logic [31:0] spec_res_q;
  logic        spec_dbz_q;
  logic        sign_q;
  logic [7:0]  ea_q;
  logic [7:0]  eb_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [24:0] q_q;
  logic [4:0]  cnt_q;

  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        sign_in;
  logic        spec_hit;
  logic [31:0] spec_res;
  logic        spec_dbz;

  assign a_exp   = bus.floatA[30:23];
  assign a_frac  = bus.floatA[22:0];
  assign b_exp   = bus.floatB[30:23];
  assign b_frac  = bus.floatB[22:0];
  assign a_zero  = (a_exp == 8'd0);
  assign b_zero  = (b_exp == 8'd0);
  assign a_inf   = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf   = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan   = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign sign_in = bus.floatA[31] ^ bus.floatB[31];

  // Priority matters: NaN-producing cases first, then Inf/0 before 0/x and x/Inf.
  always_comb begin
    spec_hit = 1'b1;
    spec_dbz = 1'b0;
    spec_res = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = 32'h7FC00000;
    end else if (a_inf) begin
      spec_res = {sign_in, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_res = {sign_in, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {sign_in, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic        ge;
  logic [23:0] rem_sub;
  logic [24:0] rem_d;
  logic [24:0] q_d;

  // rem < 2*mB always holds, so the difference fits in 24 bits.
  assign ge      = (rem_q >= {1'b0, mb_q});
  assign rem_sub = ge ? (rem_q[23:0] - mb_q) : rem_q[23:0];
  assign rem_d   = {rem_sub, 1'b0};
  assign q_d     = {q_q[23:0], ge};

  logic signed [9:0] e_d;
  logic [22:0]       frac_n;
  logic [31:0]       norm_res;

  assign e_d    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                + (q_q[24] ? 10'sd127 : 10'sd126);
  assign frac_n = q_q[24] ? q_q[23:1] : q_q[22:0];

  always_comb begin
    norm_res = {sign_q, e_d[7:0], frac_n};
    if (e_d >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'd0};
    end else if (e_d <= 10'sd0) begin
      norm_res = {sign_q, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      quot_q      <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      spec_pend_q <= 1'b0;
      spec_res_q  <= 32'd0;
      spec_dbz_q  <= 1'b0;
      sign_q      <= 1'b0;
      ea_q        <= 8'd0;
      eb_q        <= 8'd0;
      mb_q        <= 24'd0;
      rem_q       <= 25'd0;
      q_q         <= 25'd0;
      cnt_q       <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (spec_pend_q) begin
            quot_q      <= spec_res_q;
            dbz_q       <= spec_dbz_q;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            spec_pend_q <= 1'b0;
          end else if (bus.start) begin
            busy_q <= 1'b1;
            sign_q <= sign_in;
            ea_q   <= a_exp;
            eb_q   <= b_exp;
            mb_q   <= {1'b1, b_frac};
            rem_q  <= {2'b01, a_frac};
            q_q    <= 25'd0;
            cnt_q  <= 5'd0;
            if (spec_hit) begin
              spec_pend_q <= 1'b1;
              spec_res_q  <= spec_res;
              spec_dbz_q  <= spec_dbz;
            end else begin
              state_q <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd24) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          quot_q  <= norm_res;
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_float_div_seq.sv
// Bench for float_div_seq: vector table plus handshake/reset sequences,
// results checked by a done-triggered scoreboard.
module tb_float_div_seq;

  logic clk;
  logic reset;

  float_div_seq_if bus ();

  float_div_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
      end
      if (prev_done) check("done_pulse_width", 32'd2, 32'd1);
    end
    prev_done = bus.done;
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic dbz, input int lat_exp);
    int lat;
    bus.start  = 1'b1;
    bus.floatA = a;
    bus.floatB = b;
    sb.push_back('{q, dbz});
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, lat_exp);
    check("busy_in_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int   lat;
    int   n;

    vecs = '{
      '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 26},
      '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26},
      '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 26},
      '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26},
      '{32'h3FC00000, 32'h3FA00000, 32'h3F999999, 1'b0, 26},
      '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1},
      '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 26},
      '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1},
      '{32'h00000000, 32'hBF800000, 32'h80000000, 1'b0, 1},
      '{32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1},
      '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26},
      '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1},
      '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1},
      '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1},
      '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1},
      '{32'hC1200000, 32'h40A00000, 32'hC0000000, 1'b0, 26}
    };

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.floatA = 32'd0;
    bus.floatB = 32'd0;
    #1;
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz, vecs[i].lat);
    end

    // start pulsed mid-operation and operands changed after capture
    repeat (3) @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.floatA = 32'h40C00000;
    bus.floatB = 32'h40000000;
    sb.push_back('{32'h40400000, 1'b0});
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin
        bus.start  = 1'b1;
        bus.floatA = 32'h3F800000;
        bus.floatB = 32'h40400000;
      end else if (lat == 6) begin
        bus.start = 1'b0;
      end
    end
    check("ignore_latency", lat, 26);
    count_done(35, n);
    check("ignore_no_extra_done", n, 0);

    // back-to-back: second start issued in the done cycle
    bus.start  = 1'b1;
    bus.floatA = 32'h3F800000;
    bus.floatB = 32'h40400000;
    sb.push_back('{32'h3EAAAAAA, 1'b0});
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_latency", lat, 26);
    bus.start  = 1'b1;
    bus.floatA = 32'hC0C00000;
    bus.floatB = 32'h40000000;
    sb.push_back('{32'hC0400000, 1'b0});
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_done_spacing", n, 27);

    // asynchronous reset at iteration 10 discards the operation
    bus.start  = 1'b1;
    bus.floatA = 32'h40C00000;
    bus.floatB = 32'h40000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_quotient", bus.quotient, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    count_done(40, n);
    check("no_done_after_reset", n, 0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);

    repeat (5) @(posedge clk); #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
